// File: rtl/alu_seq_unit.sv
// Handshaked ALU responder: single-cycle logic/arithmetic ops plus iterative
// SHL (one bit per clock) and shift-add MUL, with a held response port.
module alu_seq_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [2:0]       rsp_op,
    output logic [15:0]      done_count
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;

    logic [SHAMT_W-1:0] shamt;
    logic               is_iter;
    logic [WIDTH:0]     add_full;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   iter_result;
    logic               iter_carry;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign shamt     = req_b[SHAMT_W-1:0];
    assign is_iter   = (req_op == OP_MUL) || ((req_op == OP_SHL) && (shamt != '0));
    assign add_full  = {1'b0, req_a} + {1'b0, req_b};

    // Single-cycle results; a zero-distance SHL also resolves here as a pass-through.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (req_op)
            OP_ADD: begin
                alu_result = add_full[WIDTH-1:0];
                alu_carry  = add_full[WIDTH];
            end
            OP_SUB: begin
                alu_result = req_a - req_b;
                alu_carry  = (req_a < req_b);
            end
            OP_AND:  alu_result = req_a & req_b;
            OP_OR:   alu_result = req_a | req_b;
            OP_XOR:  alu_result = req_a ^ req_b;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
            OP_SHL:  alu_result = req_a;
            default: alu_result = '0;
        endcase
    end

    // One iteration step; the final step's value is what gets published.
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : '0);
        iter_result = {mul_sum[0], acc_lo[WIDTH-1:1]};
        iter_carry  = (mul_sum[WIDTH:1] != '0);
        if (op_r == OP_SHL) begin
            iter_result = op_a << 1;
            iter_carry  = op_a[WIDTH-1];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = is_iter ? BUSY : DONE;
            BUSY:    if (cnt == CNT_W'(1)) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_r       <= '0;
            op_a       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_op     <= '0;
            done_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_r   <= req_op;
                        op_a   <= req_a;
                        acc_hi <= '0;
                        acc_lo <= req_b;
                        cnt    <= (req_op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
                        if (!is_iter) begin
                            rsp_result <= alu_result;
                            rsp_carry  <= alu_carry;
                            rsp_zero   <= (alu_result == '0);
                            rsp_op     <= req_op;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (op_r == OP_SHL) begin
                        op_a <= op_a << 1;
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == CNT_W'(1)) begin
                        rsp_result <= iter_result;
                        rsp_carry  <= iter_carry;
                        rsp_zero   <= (iter_result == '0);
                        rsp_op     <= op_r;
                    end
                end
                DONE: begin
                    if (rsp_ready) done_count <= done_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases, randomized ops against
// an arithmetic reference model, back-pressure and mid-operation reset.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [2:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic [2:0]  rsp_op;
    logic [15:0] done_count;

    int checks   = 0;
    int failures = 0;
    int expDone  = 0;

    alu_seq_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_op     (rsp_op),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected result straight from the opcode definitions using wide arithmetic.
    function automatic void refModel(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                                     output logic [15:0] res, output logic carry, output int lat);
        logic [31:0] wide;
        int unsigned s;
        res   = '0;
        carry = 1'b0;
        lat   = 1;
        case (op)
            3'd0: begin wide = 32'(a) + 32'(b); res = wide[15:0]; carry = wide[16]; end
            3'd1: begin res = 16'(a - b); carry = (a < b); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'd6: begin
                s     = 32'(b) % 16;
                wide  = 32'(a) << s;
                res   = wide[15:0];
                carry = (s == 0) ? 1'b0 : wide[16];
                lat   = int'(s) + 1;
            end
            default: begin
                wide  = 32'(a) * 32'(b);
                res   = wide[15:0];
                carry = (wide[31:16] != 16'h0);
                lat   = 17;
            end
        endcase
    endfunction

    // Issue one request, measure latency, optionally stall the response, then retire it.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input int hold);
        logic [15:0] er;
        logic        ec;
        int          el;
        int          lat;
        bit          busyOk;
        refModel(a, b, op, er, ec, el);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        @(posedge clk); #1;
        req_a = 16'($urandom); req_b = 16'($urandom); req_op = 3'($urandom_range(0, 7));
        lat = 1;
        busyOk = 1'b1;
        while (!rsp_valid && lat < 100) begin
            if (req_ready) busyOk = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        checkOutput("latency", 32'(lat), 32'(el));
        checkOutput("ready_low_busy", 32'(busyOk), 32'd1);
        checkOutput("result", 32'(rsp_result), 32'(er));
        checkOutput("carry", 32'(rsp_carry), 32'(ec));
        checkOutput("zero", 32'(rsp_zero), 32'(er == 16'h0));
        checkOutput("rsp_op", 32'(rsp_op), 32'(op));
        checkOutput("ready_low_done", 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_result", 32'(rsp_result), 32'(er));
            checkOutput("hold_ready", 32'(req_ready), 32'd0);
            checkOutput("hold_count", 32'(done_count), 32'(expDone));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        expDone = (expDone + 1) % 65536;
        checkOutput("done_count", 32'(done_count), 32'(expDone));
        checkOutput("back_idle_valid", 32'(rsp_valid), 32'd0);
        checkOutput("back_idle_ready", 32'(req_ready), 32'd1);
    endtask

    logic [15:0] dirA  [8] = '{16'hFFFF, 16'd3, 16'h8000, 16'h8001, 16'hC000, 16'h1234, 16'h0100, 16'd7};
    logic [15:0] dirB  [8] = '{16'h0001, 16'd5, 16'h0001, 16'h0004, 16'h0001, 16'h0010, 16'h0100, 16'd9};
    logic [2:0]  dirOp [8] = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7};

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_op = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_result", 32'(rsp_result), 32'd0);
        checkOutput("rst_carry", 32'(rsp_carry), 32'd0);
        checkOutput("rst_zero", 32'(rsp_zero), 32'd0);
        checkOutput("rst_op", 32'(rsp_op), 32'd0);
        checkOutput("rst_done_count", 32'(done_count), 32'd0);

        for (int i = 0; i < 8; i++) applyStimulus(dirA[i], dirB[i], dirOp[i], 0);
        applyStimulus(16'hAAAA, 16'hFFFF, 3'd4, 5);

        for (int i = 0; i < 30; i++)
            applyStimulus(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3));

        // Abort a multiply on its 8th BUSY cycle.
        req_a = 16'h1234; req_b = 16'h5678; req_op = 3'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
            checkOutput("mul_busy_ready", 32'(req_ready), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expDone = 0;
        checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_result", 32'(rsp_result), 32'd0);
        checkOutput("abort_carry", 32'(rsp_carry), 32'd0);
        checkOutput("abort_zero", 32'(rsp_zero), 32'd0);
        checkOutput("abort_op", 32'(rsp_op), 32'd0);
        checkOutput("abort_done_count", 32'(done_count), 32'd0);
        repeat (20) begin
            @(posedge clk); #1;
            checkOutput("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        applyStimulus(16'd2, 16'd2, 3'd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
